// File: rtl/uart2udp_packer_if.sv
// uart2udp_packer_if: UART byte input, UDP payload/handshake output and
// status signals of the UART-to-UDP packer.
// slave  = packer side, master = environment (UART receiver / UDP sender).
interface uart2udp_packer_if #(
  parameter int DEPTH = 1024
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          uart_rx_done;
  logic [7:0]    uart_rx_data;
  logic          tx_done;
  logic          rec_en;
  logic [7:0]    rec_data;
  logic          tx_start_en;
  logic [15:0]   tx_byte_num;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport slave (
    input  uart_rx_done, uart_rx_data, tx_done,
    output rec_en, rec_data, tx_start_en, tx_byte_num, busy, fifo_count, overflow
  );

  modport master (
    output uart_rx_done, uart_rx_data, tx_done,
    input  rec_en, rec_data, tx_start_en, tx_byte_num, busy, fifo_count, overflow
  );
endinterface

// File: rtl/uart2udp_packer.sv
// uart2udp_packer: buffers UART bytes in a circular FIFO and hands them to a
// UDP transmitter as packets of PKT_LEN bytes.
// Optional feature: define UART2UDP_IDLE_FLUSH_EN to also flush a partial
// packet once the UART line has been silent for IDLE_CYCLES cycles.
module uart2udp_packer #(
  parameter int DEPTH       = 1024,
  parameter int PKT_LEN     = 256,
  parameter int IDLE_CYCLES = 50000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  uart2udp_packer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_START, S_WAIT} state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic [CW-1:0] len_q, cnt_q;
  logic          rec_en_q, tx_start_q, busy_q;
  logic [7:0]    rec_data_q;
  logic [15:0]   tx_num_q;

  logic full, wr_en, rd_en, timeout, pkt_ready, part_ready;

  // Full FIFO drops the byte even if a pop happens in the same cycle.
  assign full       = (count_q == CW'(DEPTH));
  assign wr_en      = bus.uart_rx_done && !full;
  assign rd_en      = (state_q == S_DRAIN) && (cnt_q < len_q);
  assign pkt_ready  = (count_q >= CW'(PKT_LEN));
  assign part_ready = (count_q != '0) && timeout;

`ifdef UART2UDP_IDLE_FLUSH_EN
  localparam int TW = $clog2(IDLE_CYCLES + 1);
  logic [TW-1:0] idle_q;

  // Cycles since the last UART byte, saturating at IDLE_CYCLES.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                           idle_q <= '0;
    else if (bus.uart_rx_done)             idle_q <= '0;
    else if (idle_q != TW'(IDLE_CYCLES))   idle_q <= idle_q + TW'(1);
  end

  assign timeout = (idle_q == TW'(IDLE_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  // Byte storage; contents need no reset since pointers define validity.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.uart_rx_data;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
      if (bus.uart_rx_done && full) overflow_q <= 1'b1;
    end
  end

  // Packet FSM with registered outputs. DRAIN spends len cycles popping and
  // one more cycle while the last popped byte is on rec_data, so START
  // follows the final rec_en directly.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      rec_en_q   <= 1'b0;
      rec_data_q <= '0;
      tx_start_q <= 1'b0;
      tx_num_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      rec_en_q   <= rd_en;
      if (rd_en) rec_data_q <= mem_q[rd_ptr_q];
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (pkt_ready) begin
            len_q   <= CW'(PKT_LEN);
            state_q <= S_DRAIN;
            busy_q  <= 1'b1;
          end else if (part_ready) begin
            len_q   <= count_q;
            state_q <= S_DRAIN;
            busy_q  <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt_q == len_q) begin
            state_q    <= S_START;
            tx_start_q <= 1'b1;
            tx_num_q   <= 16'(len_q);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (bus.tx_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rec_en      = rec_en_q;
  assign bus.rec_data    = rec_data_q;
  assign bus.tx_start_en = tx_start_q;
  assign bus.tx_byte_num = tx_num_q;
  assign bus.busy        = busy_q;
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_uart2udp_packer.sv
// Scoreboard bench for uart2udp_packer (DEPTH=16, PKT_LEN=8, IDLE_CYCLES=20).
// Stimulus pushes expected payload bytes and packet lengths; the monitor pops
// and compares whenever rec_en / tx_start_en are seen.
module tb_uart2udp_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0, failures = 0;
  int   cyc = 0;
  int   rec_seen = 0, tx_seen = 0;
  int   run = 0, first_rec_cyc = 0, last_start = 0, prev_start = 0, last_wr_cyc = 0;
  bit   prev_rec = 0, prev_st = 0, tx_auto = 0;
  logic [7:0] exp_bytes[$];
  int         exp_len[$];

  uart2udp_packer_if #(.DEPTH(16)) tb_if();

  uart2udp_packer #(.DEPTH(16), .PKT_LEN(8), .IDLE_CYCLES(20)) dut (
    .sys_clk(clk), .sys_rst(rst), .bus(tb_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      run = 0; prev_rec = 0; prev_st = 0;
    end else begin
      if (tb_if.rec_en) begin
        if (!prev_rec) first_rec_cyc = cyc;
        run++; rec_seen++;
        if (exp_bytes.size() == 0) chk("unexpected_rec_en", 1, 0);
        else chk("rec_data", tb_if.rec_data, exp_bytes.pop_front());
      end else if (prev_rec && !tx_start_en_now()) begin
        chk("rec_en_gap", 1, 0);
      end
      if (tb_if.tx_start_en) begin
        tx_seen++;
        prev_start = last_start; last_start = cyc;
        chk("start_one_cycle", prev_st, 0);
        chk("start_after_rec", prev_rec, 1);
        if (exp_len.size() == 0) chk("unexpected_tx_start", 1, 0);
        else begin
          int e;
          e = exp_len.pop_front();
          chk("tx_byte_num", tb_if.tx_byte_num, e);
          chk("rec_run_len", run, e);
        end
        run = 0;
      end
      prev_rec = tb_if.rec_en;
      prev_st  = tb_if.tx_start_en;
    end
  end

  function automatic bit tx_start_en_now();
    return tb_if.tx_start_en;
  endfunction

  // UDP side: acknowledge each packet a few cycles after tx_start_en.
  always @(negedge clk) begin
    if (!rst && tb_if.tx_start_en && tx_auto) begin
      repeat (3) @(negedge clk);
      tb_if.tx_done = 1'b1;
      @(negedge clk);
      tb_if.tx_done = 1'b0;
    end
  end

  task automatic send(input logic [7:0] first, input int n, input int npush);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tb_if.uart_rx_done = 1'b1;
      tb_if.uart_rx_data = first + 8'(i);
      if (i < npush) exp_bytes.push_back(first + 8'(i));
      last_wr_cyc = cyc;
    end
    @(negedge clk);
    tb_if.uart_rx_done = 1'b0;
  endtask

  // Wait until n packets have started and the packer is idle again.
  task automatic wait_pkts(input string name, input int n);
    int k = 0;
    while ((tx_seen < n || tb_if.busy) && k < 2000) begin
      @(negedge clk); #1; k++;
    end
    chk({name, "_timeout"}, int'(k >= 2000), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_bytes.delete(); exp_len.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int base, k;
    #200_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    tb_if.uart_rx_done = 1'b0;
    tb_if.uart_rx_data = '0;
    tb_if.tx_done      = 1'b0;

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    chk("rst_rec_en", tb_if.rec_en, 0);
    chk("rst_tx_start", tb_if.tx_start_en, 0);
    chk("rst_busy", tb_if.busy, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_count", tb_if.fifo_count, 0);
    chk("post_rst_overflow", tb_if.overflow, 0);
    chk("post_rst_byte_num", tb_if.tx_byte_num, 0);
    chk("post_rst_rec_data", tb_if.rec_data, 0);

    // Full packet 0x01..0x08
    tx_auto = 1;
    exp_len.push_back(8);
    send(8'h01, 8, 8);
    wait_pkts("full_pkt", 1);
    chk("full_pkt_count", tb_if.fifo_count, 0);

    // tx_done outside WAIT_DONE is ignored
    @(negedge clk); tb_if.tx_done = 1'b1;
    @(negedge clk); tb_if.tx_done = 1'b0;
    #1 chk("stray_tx_done_busy", tb_if.busy, 0);

`ifdef UART2UDP_IDLE_FLUSH_EN
    // Idle flush of a 3-byte partial packet
    exp_len.push_back(3);
    send(8'h31, 3, 3);
    k = last_wr_cyc;
    wait_pkts("flush", 2);
    chk("flush_delay_ok", int'((first_rec_cyc - k) >= 21 && (first_rec_cyc - k) <= 25), 1);
`else
    // Without idle flush a partial packet waits indefinitely
    base = tx_seen;
    send(8'h31, 3, 0);
    repeat (1000) @(negedge clk);
    chk("noflush_no_start", tx_seen - base, 0);
    chk("noflush_count", tb_if.fifo_count, 3);
    chk("noflush_busy", tb_if.busy, 0);
    do_reset();
`endif

    // Simultaneous write and read during DRAIN
    base = rec_seen;
    exp_len.push_back(8);
    send(8'h10, 8, 8);
    k = 0;
    while (rec_seen == base && k < 100) begin @(negedge clk); #1; k++; end
    chk("simul_wait_timeout", int'(k >= 100), 0);
    chk("simul_count_before", tb_if.fifo_count, 7);
    tb_if.uart_rx_done = 1'b1; tb_if.uart_rx_data = 8'h55;
    exp_bytes.push_back(8'h55);
    @(negedge clk);
    tb_if.uart_rx_done = 1'b0;
    chk("simul_count_after", tb_if.fifo_count, 7);
    exp_len.push_back(8);
    send(8'h56, 7, 7);
    wait_pkts("simul", tx_seen + 1);

    // Overflow while WAIT_DONE is held, then back-to-back packets
    tx_auto = 0;
    base = tx_seen;
    exp_len.push_back(8);
    send(8'h40, 8, 8);
    k = 0;
    while (tx_seen == base && k < 100) begin @(negedge clk); #1; k++; end
    chk("ovf_start_timeout", int'(k >= 100), 0);
    send(8'h60, 20, 16);
    chk("ovf_count", tb_if.fifo_count, 16);
    chk("ovf_flag", tb_if.overflow, 1);
    chk("ovf_busy", tb_if.busy, 1);
    exp_len.push_back(8);
    exp_len.push_back(8);
    tx_auto = 1;
    @(negedge clk); tb_if.tx_done = 1'b1;
    @(negedge clk); tb_if.tx_done = 1'b0;
    wait_pkts("b2b", base + 3);
    chk("b2b_gap_ge10", int'((last_start - prev_start) >= 10), 1);
    chk("b2b_count", tb_if.fifo_count, 0);
    chk("ovf_sticky", tb_if.overflow, 1);

    // Reset on the 4th rec_en of a packet
    base = rec_seen;
    exp_len.push_back(8);
    send(8'h80, 8, 8);
    k = 0;
    while (rec_seen < base + 4 && k < 100) begin @(negedge clk); #1; k++; end
    chk("mid_rst_wait_timeout", int'(k >= 100), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rec_en", tb_if.rec_en, 0);
    chk("mid_rst_rec_data", tb_if.rec_data, 0);
    chk("mid_rst_tx_start", tb_if.tx_start_en, 0);
    chk("mid_rst_byte_num", tb_if.tx_byte_num, 0);
    chk("mid_rst_busy", tb_if.busy, 0);
    chk("mid_rst_count", tb_if.fifo_count, 0);
    chk("mid_rst_overflow", tb_if.overflow, 0);
    exp_bytes.delete(); exp_len.delete();
    @(negedge clk); #1 rst = 1'b0;
    base = tx_seen;
    repeat (50) @(negedge clk);
    chk("post_rst_no_start", tx_seen - base, 0);
    exp_len.push_back(8);
    send(8'h90, 8, 8);
    wait_pkts("post_rst_pkt", base + 1);

    chk("sb_bytes_empty", exp_bytes.size(), 0);
    chk("sb_len_empty", exp_len.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
